// File: rtl/axis_fifo_arbiter_pkg.sv
// rtl/axis_fifo_arbiter_pkg.sv - shared types and constants for the AXIS frame arbiter
package axis_fifo_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_e;

    localparam int FRAME_COUNT_W = 32;

    // Single-step modulo: callers guarantee 0 <= i < 2*n.
    function automatic int wrap_idx(input int i, input int n);
        return (i >= n) ? (i - n) : i;
    endfunction

endpackage

// File: rtl/axis_fifo_arbiter_if.sv
// rtl/axis_fifo_arbiter_if.sv - AXI-Stream bundle with transmitter/receiver views
interface axis_fifo_arbiter_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 8,
    parameter int TDEST_WIDTH = 8,
    parameter int TUSER_WIDTH = 1
);
    localparam int TKEEP_WIDTH = (TDATA_WIDTH + 7) / 8;

    logic [TDATA_WIDTH-1:0] tdata;
    logic [TKEEP_WIDTH-1:0] tkeep;
    logic [TKEEP_WIDTH-1:0] tstrb;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   twakeup;

    modport transmitter (
        output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser, twakeup,
        input  tready
    );

    modport receiver (
        input  tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser, twakeup,
        output tready
    );

endinterface

// File: rtl/axis_fifo_arbiter_rr_pick.sv
// rtl/axis_fifo_arbiter_rr_pick.sv - combinational round-robin pick starting after last_idx
module axis_fifo_arbiter_rr_pick
    import axis_fifo_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    localparam int IDX_W     = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req_i,
    input  logic [IDX_W-1:0]      last_idx_i,
    output logic [NUM_INPUTS-1:0] onehot_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  any_valid_o
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            cand = IDX_W'(wrap_idx(int'(last_idx_i) + k, NUM_INPUTS));
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                onehot_o[cand] = 1'b1;
                idx_o          = cand;
            end
        end
        any_valid_o = |req_i;
    end

endmodule

// File: rtl/axis_fifo_arbiter.sv
// rtl/axis_fifo_arbiter.sv - frame-granular round-robin merge of AXIS requesters into one FIFO stream
module axis_fifo_arbiter
    import axis_fifo_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS      = 4,
    parameter int DEPTH           = 4096,
    parameter int DEPTH_THRESHOLD = DEPTH - 256,
    parameter int TDATA_WIDTH     = 32,
    parameter int TID_WIDTH       = 8,
    parameter int TDEST_WIDTH     = 8,
    parameter int TUSER_WIDTH     = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    axis_fifo_arbiter_if.receiver      in_axis_if [NUM_INPUTS],
    axis_fifo_arbiter_if.transmitter   out_axis_if,
    input  logic [$clog2(DEPTH):0]     status_depth,
    output logic [NUM_INPUTS-1:0]      grant,
    output logic [FRAME_COUNT_W-1:0]   frame_count
);

    localparam int IDX_W   = $clog2(NUM_INPUTS);
    localparam int TKEEP_W = (TDATA_WIDTH + 7) / 8;

    if (NUM_INPUTS < 2 || NUM_INPUTS > 16) begin : g_bad_num_inputs
        $error("axis_fifo_arbiter: NUM_INPUTS must be in 2..16");
    end
    if ($bits(out_axis_if.tdata) != TDATA_WIDTH || $bits(out_axis_if.tid) != TID_WIDTH ||
        $bits(out_axis_if.tdest) != TDEST_WIDTH || $bits(out_axis_if.tuser) != TUSER_WIDTH) begin : g_bad_out_width
        $error("axis_fifo_arbiter: output stream widths differ from parameters");
    end

    logic [TDATA_WIDTH-1:0] in_tdata  [NUM_INPUTS];
    logic [TKEEP_W-1:0]     in_tkeep  [NUM_INPUTS];
    logic [TID_WIDTH-1:0]   in_tid    [NUM_INPUTS];
    logic [TDEST_WIDTH-1:0] in_tdest  [NUM_INPUTS];
    logic [TUSER_WIDTH-1:0] in_tuser  [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]  in_tvalid;
    logic [NUM_INPUTS-1:0]  in_tlast;

    arb_state_e               state_q, state_d;
    logic [NUM_INPUTS-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]         sel_idx_q, sel_idx_d;
    logic [IDX_W-1:0]         last_idx_q, last_idx_d;
    logic [FRAME_COUNT_W-1:0] frame_count_q, frame_count_d;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_in
        if ($bits(in_axis_if[g].tdata) != TDATA_WIDTH || $bits(in_axis_if[g].tid) != TID_WIDTH ||
            $bits(in_axis_if[g].tdest) != TDEST_WIDTH || $bits(in_axis_if[g].tuser) != TUSER_WIDTH) begin : g_bad_in_width
            $error("axis_fifo_arbiter: input stream widths differ from output");
        end
        assign in_tdata[g]  = in_axis_if[g].tdata;
        assign in_tkeep[g]  = in_axis_if[g].tkeep;
        assign in_tid[g]    = in_axis_if[g].tid;
        assign in_tdest[g]  = in_axis_if[g].tdest;
        assign in_tuser[g]  = in_axis_if[g].tuser;
        assign in_tvalid[g] = in_axis_if[g].tvalid;
        assign in_tlast[g]  = in_axis_if[g].tlast;
        // grant_q is zero in IDLE, so this also holds every tready low there.
        assign in_axis_if[g].tready = grant_q[g] & out_axis_if.tready;
    end

    logic [NUM_INPUTS-1:0] pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;

    axis_fifo_arbiter_rr_pick #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_rr_pick (
        .req_i       (in_tvalid),
        .last_idx_i  (last_idx_q),
        .onehot_o    (pick_onehot),
        .idx_o       (pick_idx),
        .any_valid_o (pick_any)
    );

    logic [TDATA_WIDTH-1:0] mux_tdata;
    logic [TKEEP_W-1:0]     mux_tkeep;
    logic [TID_WIDTH-1:0]   mux_tid;
    logic [TDEST_WIDTH-1:0] mux_tdest;
    logic [TUSER_WIDTH-1:0] mux_tuser;
    logic                   mux_tvalid;
    logic                   mux_tlast;

    always_comb begin
        mux_tdata  = '0;
        mux_tkeep  = '0;
        mux_tid    = '0;
        mux_tdest  = '0;
        mux_tuser  = '0;
        mux_tvalid = 1'b0;
        mux_tlast  = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            mux_tdata  = mux_tdata  | ({TDATA_WIDTH{grant_q[i]}} & in_tdata[i]);
            mux_tkeep  = mux_tkeep  | ({TKEEP_W{grant_q[i]}}     & in_tkeep[i]);
            mux_tid    = mux_tid    | ({TID_WIDTH{grant_q[i]}}   & in_tid[i]);
            mux_tdest  = mux_tdest  | ({TDEST_WIDTH{grant_q[i]}} & in_tdest[i]);
            mux_tuser  = mux_tuser  | ({TUSER_WIDTH{grant_q[i]}} & in_tuser[i]);
            mux_tvalid = mux_tvalid | (grant_q[i] & in_tvalid[i]);
            mux_tlast  = mux_tlast  | (grant_q[i] & in_tlast[i]);
        end
    end

    assign out_axis_if.tdata   = mux_tdata;
    assign out_axis_if.tkeep   = mux_tkeep;
    assign out_axis_if.tid     = mux_tid;
    assign out_axis_if.tdest   = mux_tdest;
    assign out_axis_if.tuser   = mux_tuser;
    assign out_axis_if.tvalid  = mux_tvalid;
    assign out_axis_if.tlast   = mux_tlast;
    assign out_axis_if.tstrb   = '0;
    assign out_axis_if.twakeup = 1'b0;

    logic depth_ok;
    logic frame_done;
    assign depth_ok   = int'(status_depth) < DEPTH_THRESHOLD;
    assign frame_done = mux_tvalid & out_axis_if.tready & mux_tlast;

    // Threshold is looked at only when starting a frame; once granted, the frame runs to tlast.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        sel_idx_d     = sel_idx_q;
        last_idx_d    = last_idx_q;
        frame_count_d = frame_count_q;
        case (state_q)
            IDLE: begin
                if (pick_any && depth_ok) begin
                    state_d   = PASS;
                    grant_d   = pick_onehot;
                    sel_idx_d = pick_idx;
                end
            end
            PASS: begin
                if (frame_done) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    last_idx_d    = sel_idx_q;
                    frame_count_d = frame_count_q + FRAME_COUNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            sel_idx_q     <= '0;
            last_idx_q    <= IDX_W'(NUM_INPUTS - 1);
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            sel_idx_q     <= sel_idx_d;
            last_idx_q    <= last_idx_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign grant       = grant_q;
    assign frame_count = frame_count_q;

endmodule

// File: doc/axis_fifo_arbiter.md
AXIS_FIFO_ARBITER -- requirements
Module: axis_fifo_arbiter

Interface
REQ-001 Parameter NUM_INPUTS, default 4, number of AXIS requesters (2..16).
REQ-002 Parameter DEPTH, default 4096, depth of the downstream FIFO; sets the status_depth width.
REQ-003 Parameter DEPTH_THRESHOLD, default DEPTH-256, FIFO fill level at or above which no new frame is granted.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_axis_if[NUM_INPUTS]  AXIS_IF.Receiver  -  requester streams, all with identical widths.
REQ-007 out_axis_if  AXIS_IF.Transmitter  -  merged stream toward the downstream FIFO.
REQ-008 status_depth  input  $clog2(DEPTH)+1  current FIFO fill level.
REQ-009 grant  output  NUM_INPUTS  one-hot index of the input owning the output; zero when idle.
REQ-010 frame_count  output  32  count of frames forwarded (tlast handshakes on output).

Function
REQ-011 States: IDLE, PASS; state held in a register.
REQ-012 IDLE: grant = 0, out tvalid = 0, all input tready = 0.
REQ-013 IDLE -> PASS when any input tvalid = 1 and status_depth < DEPTH_THRESHOLD; winner registered the same edge.
REQ-014 Round-robin: search starts at last_idx+1 modulo NUM_INPUTS; first valid index wins.
REQ-015 IDLE holds when no input is valid or status_depth >= DEPTH_THRESHOLD; threshold is checked only at frame start.
REQ-016 PASS: out tdata/tkeep/tvalid/tlast/tid/tdest/tuser = selected input's, combinationally.
REQ-017 PASS: selected input tready = out tready; non-selected inputs tready = 0.
REQ-018 out tstrb = 0 and out twakeup = 0 at all times.
REQ-019 PASS -> IDLE on out tvalid & tready & tlast; last_idx <= selected index; frame_count += 1, wrapping 2^32-1 -> 0.
REQ-020 Arbitration latency: 1 cycle from first valid in IDLE to grant; 1 idle bubble after every frame end.
REQ-021 Mid-frame, a threshold crossing or another input's tvalid has no effect; the grant is held until tlast.
REQ-022 A selected input deasserting tvalid mid-frame keeps the grant; out tvalid follows it.
REQ-023 Single-beat frame (tvalid & tlast on the first PASS cycle, tready = 1): PASS lasts one cycle.

Reset
REQ-024 Async assert: state = IDLE, grant = 0, frame_count = 0, last_idx = NUM_INPUTS-1 (input 0 has first priority).
REQ-025 Reset mid-frame aborts the frame with no recovery; the partial frame downstream is the FIFO's concern.
REQ-026 Deassertion is synchronized externally; the first arbitration is possible on the first edge after release.

Structure
REQ-027 axis_fifo_arbiter_pkg holds the state enum (IDLE, PASS) and the frame_count width constant (32).
REQ-028 One sub-module, rr_pick: combinational request vector + last_idx -> one-hot winner + index + any_valid.
REQ-029 The output mux is a for-loop AND-OR over grant; no priority encoder in the data path.
REQ-030 Elaboration assertions: NUM_INPUTS in 2..16, and input/output TDATA_WIDTH, TID_WIDTH, TDEST_WIDTH and TUSER_WIDTH equal.

Verification
REQ-031 Reset release, inputs 0 and 2 valid, status_depth = 0 -> grant = 0001 one cycle later; after its tlast, grant = 0100 after 1 bubble.
REQ-032 All 4 inputs send continuous 3-beat frames, out tready = 1 -> grant order 0,1,2,3,0; frame_count = 5 after 5 frames.
REQ-033 status_depth = DEPTH_THRESHOLD with input 1 valid -> grant stays 0; status_depth = DEPTH_THRESHOLD-1 -> grant = 0010 next cycle.
REQ-034 status_depth raised to DEPTH mid-frame on input 3 -> frame completes unchanged; next frame is blocked.
REQ-035 out tready random 50 %, 8-beat frames, tdata = input index<<8 | beat -> output data in order, no beat interleave across inputs.
REQ-036 Reset asserted on beat 2 of a frame from input 1 -> grant = 0 immediately; after release, input 0 wins if valid.
